// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad cascade: coefficient
// indices, the per-section coefficient bundle, FSM states and the
// saturate/wrap helper. IIR_SAT_EN selects clamping instead of wrap.
package iir_pkg;

    // Coefficient index k inside a section (address = sec*5 + k)
    localparam int K_B0  = 0;
    localparam int K_B1  = 1;
    localparam int K_B2  = 2;
    localparam int K_A1  = 3;
    localparam int K_A2  = 4;
    localparam int NCOEF = 5;

    // Coefficient fields are carried sign-extended to 32 bits; the datapath
    // works in 64-bit accumulators, which covers 2*WL+3 for WL up to 30.
    localparam int COEF_W = 32;

    typedef struct packed {
        logic signed [COEF_W-1:0] b0;
        logic signed [COEF_W-1:0] b1;
        logic signed [COEF_W-1:0] b2;
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
    } coef_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } iir_state_e;

    // Reduce a wide value to wl bits: clamp when saturation is built in,
    // otherwise keep the low wl bits (sign-extended back to 64).
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] x,
                                                      input int wl);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
`ifdef IIR_SAT_EN
        hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
`else
        hi = x <<< (64 - wl);
        lo = hi >>> (64 - wl);
        return lo;
`endif
    endfunction

endpackage

// File: rtl/iir_sos_dp.sv
// Combinational Direct Form II section: one biquad evaluated per clock.
// w = reduce(((v << FRAC) - a1*f1 - a2*f2) >>> FRAC)
// y = reduce((b0*w + b1*f1 + b2*f2) >>> FRAC)
// Saturation vs wrap follows IIR_SAT_EN through iir_pkg::sat_or_wrap.
module iir_sos_dp
    import iir_pkg::*;
#(
    parameter int WL   = 28,
    parameter int FRAC = 12
) (
    input  logic signed [WL-1:0] v,
    input  logic signed [WL-1:0] f1,
    input  logic signed [WL-1:0] f2,
    input  coef_t                coef,
    output logic signed [WL-1:0] w,
    output logic signed [WL-1:0] y
);

    logic signed [63:0] acc_w;
    logic signed [63:0] acc_y;

    // Feedback sum produces w, which immediately feeds the feed-forward sum
    always_comb begin
        acc_w = (64'(v) <<< FRAC)
              - 64'(coef.a1) * 64'(f1)
              - 64'(coef.a2) * 64'(f2);
        w     = WL'(sat_or_wrap(acc_w >>> FRAC, WL));
        acc_y = 64'(coef.b0) * 64'(w)
              + 64'(coef.b1) * 64'(f1)
              + 64'(coef.b2) * 64'(f2);
        y     = WL'(sat_or_wrap(acc_y >>> FRAC, WL));
    end

endmodule

// File: rtl/iir_sos_tdm.sv
// Multi-channel cascade of NSEC biquads sharing one section datapath.
// A sample is accepted in IDLE, walks through the sections one per clock in
// RUN, and is presented in HOLD until taken. Coefficients live in a small
// register file writable only in IDLE; f1/f2 state is kept per channel and
// section. Build with IIR_SAT_EN defined to saturate instead of wrap.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and while out_valid=1 the out_ch and
// out_data values hold until the transfer.
module iir_sos_tdm
    import iir_pkg::*;
#(
    parameter  int WL   = 28,
    parameter  int FRAC = 12,
    parameter  int NSEC = 3,
    parameter  int NCH  = 2,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(NCOEF * NSEC),
    localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [WL-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [WL-1:0] out_data,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [WL-1:0] coef_wdata,
    output iir_state_e           dbg_state
);

    iir_state_e           state;
    iir_state_e           state_next;
    logic [SW-1:0]        sec;
    logic [CW-1:0]        ch;
    logic signed [WL-1:0] v;
    logic signed [WL-1:0] coef_mem [NCOEF*NSEC];
    logic signed [WL-1:0] f1 [NCH][NSEC];
    logic signed [WL-1:0] f2 [NCH][NSEC];
    logic [AW-1:0]        cbase;
    coef_t                coef;
    logic signed [WL-1:0] w;
    logic signed [WL-1:0] y;
    logic                 last_sec;
    logic                 ch_ok;
    logic                 coef_ok;

    assign last_sec  = (32'(sec) == NSEC - 1);
    assign ch_ok     = (32'(in_ch) < NCH);
    assign coef_ok   = (32'(coef_addr) < NCOEF * NSEC);
    assign cbase     = AW'(32'(sec) * NCOEF);
    assign dbg_state = state;

    // Gather the active section's five coefficients for the datapath
    always_comb begin
        coef    = '0;
        coef.b0 = COEF_W'(coef_mem[cbase + AW'(K_B0)]);
        coef.b1 = COEF_W'(coef_mem[cbase + AW'(K_B1)]);
        coef.b2 = COEF_W'(coef_mem[cbase + AW'(K_B2)]);
        coef.a1 = COEF_W'(coef_mem[cbase + AW'(K_A1)]);
        coef.a2 = COEF_W'(coef_mem[cbase + AW'(K_A2)]);
    end

    iir_sos_dp #(
        .WL   (WL),
        .FRAC (FRAC)
    ) u_dp (
        .v    (v),
        .f1   (f1[ch][sec]),
        .f2   (f2[ch][sec]),
        .coef (coef),
        .w    (w),
        .y    (y)
    );

    // Next-state and handshake outputs; a sample for a nonexistent channel
    // is swallowed without leaving IDLE
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && ch_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_sec) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Coefficient file, filter state, working value and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            sec      <= '0;
            ch       <= '0;
            v        <= '0;
            out_ch   <= '0;
            out_data <= '0;
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < NSEC; s++) begin
                    f1[c][s] <= '0;
                    f2[c][s] <= '0;
                end
            end
            for (int i = 0; i < NCOEF * NSEC; i++) begin
                coef_mem[i] <= ((i % NCOEF) == K_B0) ? WL'(1 << FRAC) : '0;
            end
        end else begin
            if (coef_we && coef_ok && (state == IDLE)) begin
                coef_mem[coef_addr] <= coef_wdata;
            end
            case (state)
                IDLE: begin
                    if (in_valid && ch_ok) begin
                        ch  <= in_ch;
                        v   <= in_data;
                        sec <= '0;
                    end
                end
                RUN: begin
                    f2[ch][sec] <= f1[ch][sec];
                    f1[ch][sec] <= w;
                    v           <= y;
                    if (last_sec) begin
                        out_data <= y;
                        out_ch   <= ch;
                    end else begin
                        sec <= sec + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_sos_tdm.sv
// Directed bench for iir_sos_tdm (WL=28, FRAC=12, NSEC=3, NCH=2).
module tb_iir_sos_tdm;
    import iir_pkg::*;

    localparam int WL   = 28;
    localparam int FRAC = 12;
    localparam int NSEC = 3;
    localparam int NCH  = 2;
    localparam int CW   = 1;
    localparam int AW   = 4;

`ifdef IIR_SAT_EN
    localparam int EXP_OVF_SEC0 = 134217727;
    localparam int EXP_OVF_ALL  = 134217727;
    localparam int EXP_OVF_NEG  = -134217728;
`else
    localparam int EXP_OVF_SEC0 = -134217728;
    localparam int EXP_OVF_ALL  = 0;
    localparam int EXP_OVF_NEG  = 0;
`endif

    // clock / reset
    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [CW-1:0]        in_ch = '0;
    logic signed [WL-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [CW-1:0]        out_ch;
    logic signed [WL-1:0] out_data;
    logic                 coef_we = 1'b0;
    logic [AW-1:0]        coef_addr = '0;
    logic signed [WL-1:0] coef_wdata = '0;
    iir_state_e           dbg_state;

    always #5 clk = ~clk;

    iir_sos_tdm #(
        .WL   (WL),
        .FRAC (FRAC),
        .NSEC (NSEC),
        .NCH  (NCH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .dbg_state  (dbg_state)
    );

    // scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = AW'(addr);
        coef_wdata = WL'(data);
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    // Returns on the falling edge right after the accepting rising edge
    task automatic send_sample(input int chn, input int data, input bit co_wr,
                               input int co_addr, input int co_data, input string name);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = CW'(chn);
        in_data  = WL'(data);
        if (co_wr) begin
            coef_we    = 1'b1;
            coef_addr  = AW'(co_addr);
            coef_wdata = WL'(co_data);
        end
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " accept wait"}, 64'(n < 50), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic expect_out(input string name, input int chn, input int exp_data,
                              input bit check_lat);
        int n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) check({name, " latency"}, n, NSEC + 1);
        check({name, " ch"}, out_ch, chn);
        check({name, " data"}, out_data, exp_data);
        @(posedge clk);
        @(negedge clk);
        check({name, " valid drop"}, out_valid, 0);
        check({name, " ready back"}, in_ready, 1);
    endtask

    task automatic run_one(input int chn, input int data, input bit co_wr, input int co_addr,
                           input int co_data, input int exp_data, input string name);
        send_sample(chn, data, co_wr, co_addr, co_data, name);
        expect_out(name, chn, exp_data, 1'b1);
    endtask

    typedef struct {
        bit wr;
        int addr;
        int wdata;
        int chn;
        int data;
        int exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // passthrough after reset, then gains loaded section by section
        vecs[0] = '{0, 0,  0,     0, 4096,  4096};
        vecs[1] = '{0, 0,  0,     0, 0,     0};
        vecs[2] = '{0, 0,  0,     0, -300,  -300};
        vecs[3] = '{0, 0,  0,     1, 12345, 12345};
        vecs[4] = '{1, 0,  2048,  0, 1000,  500};
        vecs[5] = '{1, 5,  8192,  1, 1000,  1000};
        vecs[6] = '{1, 10, 1024,  0, -4000, -1000};
        vecs[7] = '{1, 15, 0,     0, 400,   100};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        check("reset in_ready after", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_ch", out_ch, 0);
        check("reset out_data", out_data, 0);
        check("reset state", dbg_state, IDLE);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) write_coef(vecs[i].addr, vecs[i].wdata);
            run_one(vecs[i].chn, vecs[i].data, 1'b0, 0, 0, vecs[i].exp_data,
                    $sformatf("vec%0d", i));
        end

        // coefficient write during RUN is ignored
        do_reset(2);
        write_coef(0, 2048);
        send_sample(0, 1000, 1'b0, 0, 0, "run_wr");
        coef_we    = 1'b1;
        coef_addr  = 0;
        coef_wdata = 8192;
        check("run_wr in_ready", in_ready, 0);
        @(negedge clk);
        coef_we = 1'b0;
        expect_out("run_wr", 0, 500, 1'b0);
        run_one(0, 1000, 1'b0, 0, 0, 500, "after_run_wr");

        // write in the same cycle as an accepted sample applies first
        run_one(0, 1000, 1'b1, 0, 1024, 250, "coincident_wr");

        // integrator with channel isolation
        do_reset(2);
        write_coef(K_A1, -4096);
        run_one(0, 100, 1'b0, 0, 0, 100, "integ0");
        run_one(1, 7,   1'b0, 0, 0, 7,   "integ1");
        run_one(0, 100, 1'b0, 0, 0, 200, "integ2");
        run_one(0, 100, 1'b0, 0, 0, 300, "integ3");

        // backpressure with a second sample waiting
        do_reset(2);
        out_ready = 1'b0;
        send_sample(1, -5555, 1'b0, 0, 0, "bp");
        begin
            int n = 1;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp latency", n, NSEC + 1);
        end
        in_valid = 1'b1;
        in_ch    = 0;
        in_data  = 777;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp valid %0d", k), out_valid, 1);
            check($sformatf("bp data %0d", k), out_data, -5555);
            check($sformatf("bp ch %0d", k), out_ch, 1);
            check($sformatf("bp in_ready %0d", k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp valid drop", out_valid, 0);
        check("bp ready back", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp next accepted", dbg_state, RUN);
        check("bp next busy", in_ready, 0);
        expect_out("bp_next", 0, 777, 1'b1);

        // overflow: wrap or clamp
        do_reset(2);
        write_coef(0, 8192);
        run_one(0, 1 << 26, 1'b0, 0, 0, EXP_OVF_SEC0, "ovf_sec0");
        write_coef(5, 8192);
        write_coef(10, 8192);
        run_one(0, 1 << 26,    1'b0, 0, 0, EXP_OVF_ALL, "ovf_all");
        run_one(0, -(1 << 26), 1'b0, 0, 0, EXP_OVF_NEG, "ovf_neg");

        // reset in the middle of RUN
        do_reset(2);
        write_coef(K_A1, -4096);
        write_coef(5, 2048);
        run_one(0, 100, 1'b0, 0, 0, 50, "pre_reset");
        send_sample(0, 100, 1'b0, 0, 0, "aborted");
        @(negedge clk);
        check("abort at sec1", dbg_state, RUN);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort valid 0", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort valid 0 after", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort out_data", out_data, 0);
        check("abort state", dbg_state, IDLE);
        write_coef(K_A1, -4096);
        run_one(0, 100, 1'b0, 0, 0, 100, "post_reset");
        run_one(0, 100, 1'b0, 0, 0, 200, "post_reset2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
